// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte FIFO feeding an LSB-first 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic                          tx_req_i,
    input  logic [7:0]                    tx_data_i,
    output logic                          tx_rdy_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t         state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [15:0]    baud_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           line_bit;
    logic           push;
    logic           pop;
    logic           bit_end;
`ifdef UART_TX_PARITY_EN
    logic           parity_bit;
`endif

    assign tx_rdy_o = (count != FULL_LVL);
    assign level_o  = count;
    assign busy_o   = (state != IDLE) | (count != '0);
    assign push     = tx_req_i & tx_rdy_o;
    assign bit_end  = (baud_cnt == '0);
    assign pop      = (count != '0) & ((state == IDLE) | ((state == STOP) & bit_end));

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Line level follows the state of the previous cycle, so tx_o lags the FSM by one clock.
    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_bit = parity_bit;
`endif
            default: line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_o      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_o <= line_bit;
            if (pop) begin
                shift_reg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^mem[rd_ptr];
`endif
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        baud_cnt <= BAUD_LOAD;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= BAUD_LOAD;
                        bit_cnt  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt  <= BAUD_LOAD;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        baud_cnt <= BAUD_LOAD;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_LOAD;
                        state    <= pop ? START : IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued, a line monitor decodes frames.
module tb_uart_tx_fifo;

    localparam int unsigned BAUD  = 4;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BAUD;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] data = 8'h00;
    logic       rdy;
    logic       tx;
    logic       busy;
    logic [2:0] level;

    uart_tx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .arst_n_i  (arst_n),
        .tx_req_i  (req),
        .tx_data_i (data),
        .tx_rdy_o  (rdy),
        .tx_o      (tx),
        .busy_o    (busy),
        .level_o   (level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frames_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor: a start bit is a low sample while idle; every cycle of every bit is captured.
    initial begin : monitor
        logic [NBITS-1:0] bits;
        logic [7:0]       e;
        bit               abort;
        bit               glitch;
        int               st;
        forever begin
            @(negedge clk);
            if (arst_n === 1'b1 && tx === 1'b0) begin
                st = cyc;
                frames_seen++;
                abort = 0;
                glitch = 0;
                bits = '0;
                for (int b = 0; b < NBITS && !abort; b++) begin
                    for (int s = 0; s < int'(BAUD) && !abort; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (arst_n !== 1'b1) abort = 1;
                        else if (s == 0) bits[b] = tx;
                        else if (tx !== bits[b]) glitch = 1;
                    end
                end
                if (!abort) begin
                    start_q.push_back(st);
                    chk("bit_width", 32'(glitch), 0);
                    chk("stop_bit", 32'(bits[NBITS-1]), 1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got %02h expected none", bits[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_byte", 32'(bits[8:1]), 32'(e));
`ifdef UART_TX_PARITY_EN
                        chk("parity", 32'(bits[9]), 32'(^e));
`endif
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] b, output bit acc, output int edge_n);
        @(negedge clk);
        req = 1'b1;
        data = b;
        acc = rdy;
        edge_n = cyc + 1;
        if (acc) exp_q.push_back(b);
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic at_cyc(input int k);
        do @(negedge clk); while (cyc < k);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && t < 6000) begin
            @(negedge clk);
            t++;
        end
        repeat (BAUD + 2) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic get_start(output int s);
        if (start_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_frame: got none expected a frame start");
            s = -1;
        end else begin
            s = start_q.pop_front();
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        bit         acc;
        int         n, e, s1, s2, n_acc, fs;
        logic [7:0] b;

        // reset
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_rdy", 32'(rdy), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_level", 32'(level), 0);
        arst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_tx", 32'(tx), 1);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_level", 32'(level), 0);

        // single byte
        push(8'h55, acc, n);
        chk("single_acc", 32'(acc), 1);
        at_cyc(n);
        chk("single_lvl_push", 32'(level), 1);
        at_cyc(n + 1);
        chk("single_lvl_pop", 32'(level), 0);
        chk("single_tx_pre", 32'(tx), 1);
        at_cyc(n + FRAME);
        chk("single_busy_hi", 32'(busy), 1);
        at_cyc(n + 2 + FRAME);
        chk("single_busy_lo", 32'(busy), 0);
        drain();
        get_start(s1);
        chk("single_start", s1, n + 2);
        start_q.delete();

        // back-to-back
        push(8'hA5, acc, n);
        push(8'h3C, acc, e);
        drain();
        get_start(s1);
        get_start(s2);
        chk("b2b_first", s1, n + 2);
        chk("b2b_gap", s2 - s1, FRAME);
        start_q.delete();

        // full
        n_acc = 0;
        n = 0;
        for (int i = 1; i <= 5; i++) begin
            push(8'(i), acc, e);
            n_acc += int'(acc);
            if (i == 1) n = e;
        end
        chk("full_accepted", n_acc, 5);
        push(8'h06, acc, e);
        chk("full_refused", 32'(acc), 0);
        chk("full_level", 32'(level), 4);
        at_cyc(n + FRAME);
        chk("full_rdy_lo", 32'(rdy), 0);
        at_cyc(n + 1 + FRAME);
        chk("full_rdy_hi", 32'(rdy), 1);
        chk("full_level_pop", 32'(level), 3);
        drain();
        start_q.delete();

        // push on the STOP-to-START pop cycle
        push(8'h11, acc, n);
        push(8'h22, acc, e);
        push(8'h33, acc, e);
        at_cyc(n + FRAME - 1);
        chk("pp_level_before", 32'(level), 2);
        push(8'h44, acc, e);
        chk("pp_edge", e, n + 1 + FRAME);
        at_cyc(n + 1 + FRAME);
        chk("pp_level_after", 32'(level), 2);
        drain();
        start_q.delete();

        // reset during data bit 3 (bit 3 forced low so the jump to idle is visible)
        b = 8'($urandom) & 8'hF7;
        push(b, acc, n);
        push(8'($urandom), acc, e);
        push(8'($urandom), acc, e);
        at_cyc(n + 2 + 4 * int'(BAUD) + 1);
        chk("mid_level", 32'(level), 2);
        chk("mid_tx_bit3", 32'(tx), 0);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 1);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        exp_q.delete();
        fs = frames_seen;
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        repeat (FRAME + 10) @(negedge clk);
        chk("mid_no_frame", frames_seen, fs);
        chk("mid_idle_tx", 32'(tx), 1);
        start_q.delete();

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(8'($urandom), acc, e);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
